// File: rtl/gate_multi_lamp.sv
// Multi-lamp logic gate tile: lamps toggle from the wire network, and the
// gate emits one-cycle pulses when its logic value flips (or randomly in FAULT mode).
module gate_multi_lamp #(
    parameter int                    LAMP_COUNT = 2,
    parameter int                    MODE       = 0,
    parameter logic [LAMP_COUNT-1:0] LAMP_INIT  = '0,
    parameter logic [15:0]           LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  logic_reset,
    input  logic [LAMP_COUNT-1:0] lamp_toggle,
    output logic [LAMP_COUNT-1:0] lamp_state,
    output logic                  out,
    output logic                  fired,
    output logic                  busy,
    output logic [7:0]            drop_count
);

    localparam int          MODE_FAULT = 6;
    localparam logic [15:0] SEED_EFF   = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;

    logic        pending;
    logic        gate_state;
    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic        v;
    logic [3:0]  ones;
    logic [3:0]  r;
    logic        fire;

    function automatic logic reduce(input logic [LAMP_COUNT-1:0] l);
        case (MODE)
            0:       return &l;
            1:       return |l;
            2:       return ~&l;
            3:       return ~|l;
            4:       return ^l;
            5:       return ~^l;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        ones = 4'd0;
        for (int i = 0; i < LAMP_COUNT; i++) begin
            ones = ones + 4'(lamp_state[i]);
        end
    end

    // r scales the low LFSR byte into 0..LAMP_COUNT-1; firing odds are popcount/LAMP_COUNT.
    assign r       = 4'(({4'b0, lfsr[7:0]} * 12'(LAMP_COUNT)) >> 8);
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign v       = reduce(lamp_state);
    assign fire    = pending && ((MODE == MODE_FAULT) ? (r < ones) : (v != gate_state));

    // out is a one-cycle pulse with no handshake; busy = pending | out flags an
    // evaluation in flight or a pulse being presented this cycle.
    assign busy = pending | out;

    always_ff @(posedge clk) begin
        if (!reset) begin
            lamp_state <= LAMP_INIT;
            gate_state <= (MODE == MODE_FAULT) ? 1'b0 : reduce(LAMP_INIT);
            pending    <= 1'b0;
            out        <= 1'b0;
            fired      <= 1'b0;
            drop_count <= 8'd0;
            lfsr       <= SEED_EFF;
        end else begin
            lamp_state <= lamp_state ^ lamp_toggle;
            pending    <= |lamp_toggle;
            lfsr       <= {lfsr[14:0], lfsr_fb};
            out        <= 1'b0;
            if (logic_reset) begin
                fired <= 1'b0;
            end
            if (pending && (MODE != MODE_FAULT)) begin
                gate_state <= v;
            end
            // A coincident logic_reset wins over the fired check, so that pulse is allowed.
            if (fire) begin
                if (fired && !logic_reset) begin
                    if (drop_count != 8'hFF) begin
                        drop_count <= drop_count + 8'd1;
                    end
                end else begin
                    out   <= 1'b1;
                    fired <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_multi_lamp.sv
// Bench for gate_multi_lamp: four gate configurations share clock and reset,
// a popcount-based reference model feeds an expected queue drained by a monitor.
module tb_gate_multi_lamp;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] tog0 = '0;
    logic [1:0] tog1 = '0;
    logic [3:0] tog2 = '0;
    logic [0:0] tog3 = '0;
    logic       lr0 = 1'b0, lr1 = 1'b0, lr2 = 1'b0, lr3 = 1'b0;
    logic [2:0] lamp0;
    logic [1:0] lamp1;
    logic [3:0] lamp2;
    logic [0:0] lamp3;
    logic       out0, out1, out2, out3;
    logic       fired0, fired1, fired2, fired3;
    logic       busy0, busy1, busy2, busy3;
    logic [7:0] drop0, drop1, drop2, drop3;

    int vectors = 0;
    int miscompares = 0;
    int pulse_cnt2 = 0;

    localparam int W = 76;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    gate_multi_lamp #(.LAMP_COUNT(3), .MODE(0), .LAMP_INIT(3'b000), .LFSR_SEED(16'h1234)) u_and3 (
        .clk(clk), .reset(reset), .logic_reset(lr0), .lamp_toggle(tog0), .lamp_state(lamp0),
        .out(out0), .fired(fired0), .busy(busy0), .drop_count(drop0));
    gate_multi_lamp #(.LAMP_COUNT(2), .MODE(4), .LAMP_INIT(2'b00), .LFSR_SEED(16'hACE1)) u_xor2 (
        .clk(clk), .reset(reset), .logic_reset(lr1), .lamp_toggle(tog1), .lamp_state(lamp1),
        .out(out1), .fired(fired1), .busy(busy1), .drop_count(drop1));
    gate_multi_lamp #(.LAMP_COUNT(4), .MODE(6), .LAMP_INIT(4'b0000), .LFSR_SEED(16'h0000)) u_flt4 (
        .clk(clk), .reset(reset), .logic_reset(lr2), .lamp_toggle(tog2), .lamp_state(lamp2),
        .out(out2), .fired(fired2), .busy(busy2), .drop_count(drop2));
    gate_multi_lamp #(.LAMP_COUNT(1), .MODE(3), .LAMP_INIT(1'b1), .LFSR_SEED(16'hBEEF)) u_nor1 (
        .clk(clk), .reset(reset), .logic_reset(lr3), .lamp_toggle(tog3), .lamp_state(lamp3),
        .out(out3), .fired(fired3), .busy(busy3), .drop_count(drop3));

    // ---------------- reference model ----------------
    logic [7:0]  m_lamp[4];
    logic        m_gs[4], m_pend[4], m_fired[4], m_out[4];
    logic [7:0]  m_drop[4];
    logic [15:0] m_lfsr[4];

    function automatic int lc_of(int i);
        case (i) 0: return 3; 1: return 2; 2: return 4; default: return 1; endcase
    endfunction
    function automatic int mode_of(int i);
        case (i) 0: return 0; 1: return 4; 2: return 6; default: return 3; endcase
    endfunction
    function automatic logic [7:0] init_of(int i);
        return (i == 3) ? 8'd1 : 8'd0;
    endfunction
    function automatic logic [15:0] seed_of(int i);
        case (i) 0: return 16'h1234; 1: return 16'hACE1; 2: return 16'h0000; default: return 16'hBEEF; endcase
    endfunction

    function automatic int popc(logic [7:0] x);
        int n = 0;
        for (int b = 0; b < 8; b++) n += int'(x[b]);
        return n;
    endfunction

    function automatic logic gate_val(int mode, int lc, logic [7:0] l);
        int p = popc(l);
        case (mode)
            0: return p == lc;
            1: return p > 0;
            2: return p != lc;
            3: return p == 0;
            4: return (p % 2) == 1;
            5: return (p % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step(input int i, input logic rst_v, input logic [7:0] t, input logic lrv);
        int lc, mode, p, r;
        logic v, fire;
        lc = lc_of(i);
        mode = mode_of(i);
        if (!rst_v) begin
            m_lamp[i]  = init_of(i);
            m_gs[i]    = (mode == 6) ? 1'b0 : gate_val(mode, lc, init_of(i));
            m_pend[i]  = 1'b0;
            m_out[i]   = 1'b0;
            m_fired[i] = 1'b0;
            m_drop[i]  = 8'd0;
            m_lfsr[i]  = (seed_of(i) == 16'h0) ? 16'hACE1 : seed_of(i);
        end else begin
            fire = 1'b0;
            if (m_pend[i]) begin
                if (mode == 6) begin
                    p = popc(m_lamp[i]);
                    r = (int'(m_lfsr[i] % 16'd256) * lc) / 256;
                    fire = r < p;
                end else begin
                    v = gate_val(mode, lc, m_lamp[i]);
                    fire = (v != m_gs[i]);
                    m_gs[i] = v;
                end
            end
            if (fire && m_fired[i] && !lrv) begin
                m_out[i] = 1'b0;
                if (m_drop[i] < 8'd255) m_drop[i] = m_drop[i] + 8'd1;
            end else if (fire) begin
                m_out[i] = 1'b1;
                m_fired[i] = 1'b1;
            end else begin
                m_out[i] = 1'b0;
                if (lrv) m_fired[i] = 1'b0;
            end
            m_lamp[i] = m_lamp[i] ^ t;
            m_pend[i] = (t != 8'd0);
            m_lfsr[i] = {m_lfsr[i][14:0], m_lfsr[i][15] ^ m_lfsr[i][13] ^ m_lfsr[i][12] ^ m_lfsr[i][10]};
        end
    endtask

    function automatic logic [18:0] pack_model(int i);
        return {m_lamp[i], m_out[i], m_fired[i], m_pend[i] | m_out[i], m_drop[i]};
    endfunction

    // ---------------- driver ----------------
    task automatic apply(input logic rst_v, input logic [7:0] t0, input logic [7:0] t1,
                         input logic [7:0] t2, input logic [7:0] t3, input logic [3:0] lrv);
        @(negedge clk);
        reset = rst_v;
        tog0 = t0[2:0];
        tog1 = t1[1:0];
        tog2 = t2[3:0];
        tog3 = t3[0:0];
        lr0 = lrv[0]; lr1 = lrv[1]; lr2 = lrv[2]; lr3 = lrv[3];
        model_step(0, rst_v, {5'b0, t0[2:0]}, lrv[0]);
        model_step(1, rst_v, {6'b0, t1[1:0]}, lrv[1]);
        model_step(2, rst_v, {4'b0, t2[3:0]}, lrv[2]);
        model_step(3, rst_v, {7'b0, t3[0]}, lrv[3]);
        exp_q.push_back({pack_model(3), pack_model(2), pack_model(1), pack_model(0)});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 4'd0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] e;
        logic [18:0]  act[4];
        forever begin
            @(posedge clk);
            #1;
            if (out2) pulse_cnt2++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act[0] = {5'b0, lamp0, out0, fired0, busy0, drop0};
                act[1] = {6'b0, lamp1, out1, fired1, busy1, drop1};
                act[2] = {4'b0, lamp2, out2, fired2, busy2, drop2};
                act[3] = {7'b0, lamp3, out3, fired3, busy3, drop3};
                for (int i = 0; i < 4; i++) begin
                    vectors++;
                    if (act[i] !== e[19*i +: 19]) begin
                        miscompares++;
                        $display("FAIL sb_inst%0d t=%0t: got {lamp,out,fired,busy,drop}=%h expected %h",
                                 i, $time, act[i], e[19*i +: 19]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // reset values
        apply(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 4'd0);
        apply(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 4'd0);
        chk("rst_lamp3", int'(lamp3), 1);
        chk("rst_lamp0", int'(lamp0), 0);
        chk("rst_busy_out", int'({busy0, busy1, busy2, busy3, out0, out1, out2, out3}), 0);
        chk("rst_fired", int'({fired0, fired1, fired2, fired3}), 0);
        chk("rst_drop", int'(drop0) + int'(drop1) + int'(drop2) + int'(drop3), 0);

        // AND3: first firing, then suppression, then logic_reset re-arms
        apply(1'b1, 8'b111, 8'd0, 8'd0, 8'd0, 4'd0);
        apply(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 4'd0);
        chk("and3_lamp_c1", int'(lamp0), 7);
        chk("and3_out_c1", int'(out0), 0);
        apply(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 4'd0);
        chk("and3_out_c2", int'(out0), 1);
        chk("and3_fired_c2", int'(fired0), 1);
        apply(1'b1, 8'b001, 8'd0, 8'd0, 8'd0, 4'd0);
        chk("and3_out_c3", int'(out0), 0);
        apply(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 4'd0);
        chk("and3_lamp_110", int'(lamp0), 6);
        apply(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0001);
        chk("and3_suppressed_out", int'(out0), 0);
        chk("and3_drop_1", int'(drop0), 1);
        apply(1'b1, 8'b001, 8'd0, 8'd0, 8'd0, 4'd0);
        apply(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 4'd0);
        apply(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 4'd0);
        chk("and3_rearm_out", int'(out0), 1);
        chk("and3_rearm_drop", int'(drop0), 1);

        // XOR2: back-to-back toggles of lamp0, logic_reset coincident with first evaluation
        apply(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 4'd0);
        apply(1'b1, 8'd0, 8'b01, 8'd0, 8'd0, 4'd0);
        apply(1'b1, 8'd0, 8'b01, 8'd0, 8'd0, 4'b0010);
        apply(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 4'd0);
        chk("xor2_out_first", int'(out1), 1);
        apply(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 4'd0);
        chk("xor2_out_second", int'(out1), 0);
        chk("xor2_drop", int'(drop1), 1);

        // Reset mid-evaluation suppresses the pulse
        apply(1'b1, 8'b111, 8'd0, 8'd0, 8'd0, 4'd0);
        apply(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 4'd0);
        apply(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 4'd0);
        chk("midrst_lamp", int'(lamp0), 0);
        chk("midrst_out", int'(out0), 0);
        chk("midrst_drop", int'(drop0), 0);
        apply(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 4'd0);
        chk("midrst_out_later", int'(out0), 0);

        // FAULT4: all-on evaluations always fire, all-off never
        apply(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 4'd0);
        idle(2);
        pulse_cnt2 = 0;
        for (int k = 0; k < 100; k++) begin
            apply(1'b1, 8'd0, 8'd0, 8'hF, 8'd0, 4'd0);
            apply(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0100);
            apply(1'b1, 8'd0, 8'd0, 8'hF, 8'd0, 4'd0);
            apply(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0100);
        end
        idle(3);
        chk("fault_on_off_pulses", pulse_cnt2, 100);

        // FAULT4: two lamps on, roughly half of evaluations fire
        pulse_cnt2 = 0;
        for (int k = 0; k < 1000; k++) begin
            apply(1'b1, 8'd0, 8'd0, 8'h3, 8'd0, 4'd0);
            apply(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0100);
            apply(1'b1, 8'd0, 8'd0, 8'h3, 8'd0, 4'd0);
            apply(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0100);
        end
        idle(3);
        chk("fault_two_on_ratio_ok", int'(pulse_cnt2 >= 350 && pulse_cnt2 <= 650), 1);

        // AND3 drop_count saturation
        apply(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 4'd0);
        apply(1'b1, 8'b111, 8'd0, 8'd0, 8'd0, 4'd0);
        for (int k = 0; k < 310; k++) apply(1'b1, 8'b001, 8'd0, 8'd0, 8'd0, 4'd0);
        idle(3);
        chk("sat_drop", int'(drop0), 255);
        for (int k = 0; k < 6; k++) apply(1'b1, 8'b001, 8'd0, 8'd0, 8'd0, 4'd0);
        idle(3);
        chk("sat_drop_hold", int'(drop0), 255);

        // Randomized traffic on all instances
        for (int k = 0; k < 1500; k++) begin
            logic rst_v;
            logic [3:0] lrv;
            rst_v = ($urandom_range(0, 299) != 0);
            for (int j = 0; j < 4; j++) lrv[j] = ($urandom_range(0, 7) == 0);
            apply(rst_v,
                  ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 7)) : 8'd0,
                  ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'd0,
                  ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 15)) : 8'd0,
                  ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 1)) : 8'd0,
                  lrv);
        end
        idle(4);
        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
